// File: rtl/alu_seq.sv
// Registered 8-op ALU with valid/ready handshakes.
// MUL runs as a WIDTH-cycle shift-add loop; other ops finish in one cycle.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       status
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [3:0]         status_q, status_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW:0]       cnt_q, cnt_d;

  logic [WIDTH:0]     add_w, sub_w, shl_w;
  logic [WIDTH-1:0]   res;
  logic               res_c, res_v;
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0]   mul_lo, mul_hi;

  assign in_ready  = (state_q == S_IDLE) & ~reset;
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign status    = status_q;

  always_comb begin
    add_w = {1'b0, Ain} + {1'b0, Bin};
    sub_w = {1'b0, Ain} - {1'b0, Bin};
    // Bit WIDTH of the widened shift is the last bit shifted out
    shl_w = {1'b0, Ain} << Bin[SHW-1:0];
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    unique case (ALUop)
      3'b000: begin
        res   = add_w[WIDTH-1:0];
        res_c = add_w[WIDTH];
        res_v = (Ain[WIDTH-1] == Bin[WIDTH-1]) &&
                (res[WIDTH-1] != Ain[WIDTH-1]);
      end
      3'b001: begin
        res   = sub_w[WIDTH-1:0];
        res_c = sub_w[WIDTH];
        res_v = (Ain[WIDTH-1] != Bin[WIDTH-1]) &&
                (res[WIDTH-1] != Ain[WIDTH-1]);
      end
      3'b010: res = Ain & Bin;
      3'b011: res = ~Bin;
      3'b100: res = Ain | Bin;
      3'b101: res = Ain ^ Bin;
      3'b110: begin
        res   = shl_w[WIDTH-1:0];
        res_c = shl_w[WIDTH];
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_lo  = mul_sum[WIDTH-1:0];
    mul_hi  = mul_sum[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    status_d = status_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (ALUop == 3'b111) begin
            mcand_d  = {{WIDTH{1'b0}}, Ain};
            mplier_d = Bin;
            acc_d    = '0;
            cnt_d    = CNT_INIT;
            state_d  = S_MUL;
          end else begin
            out_d    = res;
            status_d = {res_c, res == '0,
                        res_v, res[WIDTH-1]};
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          out_d    = mul_lo;
          status_d = {1'b0, mul_lo == '0,
                      |mul_hi, mul_lo[WIDTH-1]};
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      status_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      status_q <= status_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16.
// Hand-computed vectors, latency, backpressure and mid-MUL reset.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Ain, Bin;
  logic [2:0]  ALUop;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_w;
  logic [3:0]  status;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out_w), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Issue one op, wait for the result, check it, optionally ack.
  task automatic run(input string tag,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic [2:0] op,
                     input logic [15:0] eo,
                     input logic [3:0] es,
                     input int elat,
                     input bit ack);
    int lat;
    bit ir_hi;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    Ain = a;
    Bin = b;
    ALUop = op;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    Ain = 16'hDEAD;
    Bin = 16'hBEEF;
    lat = 1;
    ir_hi = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ir_hi = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " busy"}, 32'(ir_hi | in_ready), 32'd0);
    chk({tag, " out"}, 32'(out_w), 32'(eo));
    chk({tag, " status"}, 32'(status), 32'(es));
    if (ack) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, " idle"},
          32'({out_valid, in_ready, out_w}),
          32'({2'b01, eo}));
    end
  endtask

  initial begin
    bit stable;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    Ain = '0;
    Bin = '0;
    ALUop = '0;
    repeat (2) @(negedge clk);
    chk("reset outputs",
        32'({in_ready, out_valid, status, out_w}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post reset ready", 32'(in_ready), 32'd1);

    run("add ovf", 16'h7FFF, 16'h0001, 3'b000,
        16'h8000, 4'b0011, 1, 1'b1);
    run("add carry", 16'hFFFF, 16'h0001, 3'b000,
        16'h0000, 4'b1100, 1, 1'b1);
    run("sub borrow", 16'h0003, 16'h0005, 3'b001,
        16'hFFFE, 4'b1001, 1, 1'b1);
    run("sub ovf", 16'h8000, 16'h0001, 3'b001,
        16'h7FFF, 4'b0010, 1, 1'b1);
    run("sub zero", 16'h1234, 16'h1234, 3'b001,
        16'h0000, 4'b0100, 1, 1'b1);
    run("mul ovf", 16'h0100, 16'h0100, 3'b111,
        16'h0000, 4'b0110, 17, 1'b1);
    run("mul 7x9", 16'h0007, 16'h0009, 3'b111,
        16'h003F, 4'b0000, 17, 1'b1);
    run("shl 1", 16'h8001, 16'h0011, 3'b110,
        16'h0002, 4'b1000, 1, 1'b1);
    run("shl 0", 16'h8001, 16'h0010, 3'b110,
        16'h8001, 4'b0001, 1, 1'b1);
    run("not", 16'h1234, 16'h00FF, 3'b011,
        16'hFF00, 4'b0001, 1, 1'b1);
    run("or", 16'h00F0, 16'h0F00, 3'b100,
        16'h0FF0, 4'b0000, 1, 1'b1);
    run("xor", 16'hFFFF, 16'h0F0F, 3'b101,
        16'hF0F0, 4'b0001, 1, 1'b1);

    run("and bp", 16'hF0F0, 16'h3C3C, 3'b010,
        16'h3030, 4'b0000, 1, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      Ain = 16'h1111;
      Bin = 16'h2222;
      ALUop = 3'b000;
      @(negedge clk);
      if (!out_valid || in_ready || out_w !== 16'h3030 ||
          status !== 4'b0000) stable = 1'b0;
    end
    chk("bp stable", 32'(stable), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp release",
        32'({out_valid, in_ready, out_w}),
        32'({2'b01, 16'h3030}));
    run("after bp", 16'h1111, 16'h2222, 3'b000,
        16'h3333, 4'b0000, 1, 1'b1);

    @(negedge clk);
    in_valid = 1'b1;
    Ain = 16'h1234;
    Bin = 16'h5678;
    ALUop = 3'b111;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid mul reset",
        32'({in_ready, out_valid, status, out_w}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run("add after abort", 16'h0002, 16'h0003, 3'b000,
        16'h0005, 4'b0000, 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
